// File: rtl/phase_seq_pkg.sv
// Shared types and constants for the clocked phase sequencer: FSM state
// encoding, dual-rail symbol values, phase indices and the wavefront helper.
package phase_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        SPACER = 2'd2,
        FAULT  = 2'd3
    } state_e;

    // Dual-rail symbols; 2'b11 is illegal and never produced.
    localparam logic [1:0] DR_NULL = 2'b00;
    localparam logic [1:0] DR_0    = 2'b01;
    localparam logic [1:0] DR_1    = 2'b10;

    localparam logic [1:0] P0 = 2'd0;
    localparam logic [1:0] P1 = 2'd1;
    localparam logic [1:0] P2 = 2'd2;

    // Packed wavefront {PH0, PH1, PH2}: the selected phase carries valid-1,
    // the other two carry valid-0.
    function automatic logic [5:0] data_wave(input logic [1:0] idx);
        logic [5:0] w;
        case (idx)
            P0:      w = {DR_1, DR_0, DR_0};
            P1:      w = {DR_0, DR_1, DR_0};
            P2:      w = {DR_0, DR_0, DR_1};
            default: w = {DR_NULL, DR_NULL, DR_NULL};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/ack_synchronizer.sv
// Multi-flop synchroniser bringing the core's asynchronous acknowledge
// into the clk domain.
module ack_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // Shift the raw input one stage deeper each cycle.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    end

    // Flop chain, cleared to "no acknowledge" on reset.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the chain into a single stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/clocked_phase_sequencer.sv
// Clocked four-phase sequencer that issues PH0 -> PH1 -> PH2 dual-rail
// tokens to the asynchronous core, counts completed instructions and
// traps a stalled core with a per-edge watchdog.
module clocked_phase_sequencer
    import phase_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             ack,
    output logic [1:0]       PH0,
    output logic [1:0]       PH1,
    output logic [1:0]       PH2,
    output logic [1:0]       phase_idx,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] instr_count
);

    localparam int                WAIT_W   = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    logic ack_s;

    state_e            state_q,     state_d;
    logic [1:0]        phase_idx_q, phase_idx_d;
    logic [WAIT_W-1:0] wait_q,      wait_d;
    logic [CNT_W-1:0]  count_q,     count_d;
    logic [5:0]        ph_q,        ph_d;
    logic              busy_q,      busy_d;
    logic              err_q,       err_d;

    ack_synchronizer #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_in(ack),
        .sync_out(ack_s)
    );

    // Next state, watchdog, counter and registered outputs from next state.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        phase_idx_d = phase_idx_q;
        wait_d      = wait_q;
        count_d     = count_q;

        case (state_q)
            IDLE: begin
                // A stale high ack blocks launch until it has fallen.
                if (run && !ack_s) begin
                    state_d     = DATA;
                    phase_idx_d = P0;
                    wait_d      = '0;
                end
            end

            DATA: begin
                if (wait_q == WAIT_MAX) begin
                    state_d = FAULT;
                end else if (ack_s) begin
                    state_d = SPACER;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            SPACER: begin
                if (wait_q == WAIT_MAX) begin
                    state_d = FAULT;
                end else if (!ack_s) begin
                    wait_d = '0;
                    if (phase_idx_q == P2) begin
                        // Instruction boundary: the only place run is honoured mid-stream.
                        count_d     = count_q + CNT_W'(1);
                        phase_idx_d = P0;
                        state_d     = run ? DATA : IDLE;
                    end else begin
                        phase_idx_d = phase_idx_q + 2'd1;
                        state_d     = DATA;
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            FAULT: begin
                state_d = FAULT;
            end

            default: begin
                state_d = FAULT;
            end
        endcase

        ph_d   = (state_d == DATA) ? data_wave(phase_idx_d) : {DR_NULL, DR_NULL, DR_NULL};
        busy_d = (state_d == DATA) || (state_d == SPACER);
        err_d  = (state_d == FAULT);
    end

    // State and output registers, all forced to spacer/idle on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            phase_idx_q <= P0;
            wait_q      <= '0;
            count_q     <= '0;
            ph_q        <= {DR_NULL, DR_NULL, DR_NULL};
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_idx_q <= phase_idx_d;
            wait_q      <= wait_d;
            count_q     <= count_d;
            ph_q        <= ph_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign PH0         = ph_q[5:4];
    assign PH1         = ph_q[3:2];
    assign PH2         = ph_q[1:0];
    assign phase_idx   = phase_idx_q;
    assign busy        = busy_q;
    assign err         = err_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_clocked_phase_sequencer.sv
// Randomised scoreboard bench: a responsive core model drives ack, the
// stimulus pushes expected wavefronts, and a monitor pops and compares on
// every wavefront change.
module tb_clocked_phase_sequencer;

    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT     = 255;

    typedef enum logic {CORE_AUTO, CORE_HOLD} core_mode_e;

    typedef struct {
        logic [5:0] wave;
        logic [1:0] idx;
        logic       busy;
        logic       err;
        logic       chk_idx;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        ack;
    logic [1:0]  PH0, PH1, PH2, phase_idx;
    logic        busy, err;
    logic [15:0] instr_count;
    logic [1:0]  w4_ph0, w4_ph1, w4_ph2, w4_phase_idx;
    logic        w4_busy, w4_err;
    logic [3:0]  w4_count;

    core_mode_e  mode;
    logic        mute_ph1;
    logic        mon_en;
    logic        illegal_seen;
    exp_t        exp_q[$];
    int unsigned model_cnt;
    int          tests;
    int          fails;

    clocked_phase_sequencer #(
        .SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .ack(ack),
        .PH0(PH0), .PH1(PH1), .PH2(PH2), .phase_idx(phase_idx),
        .busy(busy), .err(err), .instr_count(instr_count)
    );

    clocked_phase_sequencer #(
        .SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT), .CNT_W(4)
    ) dut_w4 (
        .clk(clk), .rst_n(rst_n), .run(run), .ack(ack),
        .PH0(w4_ph0), .PH1(w4_ph1), .PH2(w4_ph2), .phase_idx(w4_phase_idx),
        .busy(w4_busy), .err(w4_err), .instr_count(w4_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference wavefront: active phase carries valid-1, the rest valid-0.
    function automatic logic [5:0] ref_wave(input int k);
        logic [1:0] ph[3];
        for (int j = 0; j < 3; j++) ph[j] = (j == k) ? 2'b10 : 2'b01;
        return {ph[0], ph[1], ph[2]};
    endfunction

    function automatic exp_t mk(input logic [5:0] w, input int k, input logic b,
                                input logic e, input logic ci);
        exp_t x;
        x.wave = w; x.idx = 2'(k); x.busy = b; x.err = e; x.chk_idx = ci;
        return x;
    endfunction

    task automatic push_instr();
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(mk(ref_wave(k), k, 1'b1, 1'b0, 1'b1));
            exp_q.push_back(mk(6'b0, k, 1'b1, 1'b0, 1'b1));
        end
        model_cnt++;
    endtask

    // Core model: raises ack a random delay after a data wavefront, drops it
    // a random delay after the spacer; can hold ack high or ignore PH1.
    initial begin : core_model
        int dly;
        logic [5:0] cur;
        ack = 1'b0;
        dly = 0;
        forever begin
            @(negedge clk);
            cur = {PH0, PH1, PH2};
            if (mode == CORE_HOLD) begin
                ack = 1'b1;
                dly = 0;
            end else if (!ack) begin
                if ((PH0 == 2'b10 || PH1 == 2'b10 || PH2 == 2'b10) &&
                    !(mute_ph1 && PH1 == 2'b10)) begin
                    if (dly == 0) begin
                        ack = 1'b1;
                        dly = int'($urandom_range(0, 3));
                    end else begin
                        dly--;
                    end
                end
            end else if (cur == 6'b0) begin
                if (dly == 0) begin
                    ack = 1'b0;
                    dly = int'($urandom_range(0, 3));
                end else begin
                    dly--;
                end
            end
        end
    end

    // Monitor: on every wavefront change pop the next expectation.
    initial begin : monitor
        logic [5:0] prev, cur;
        exp_t e;
        prev = 6'b0;
        forever begin
            @(negedge clk);
            cur = {PH0, PH1, PH2};
            if (PH0 == 2'b11 || PH1 == 2'b11 || PH2 == 2'b11 ||
                w4_ph0 == 2'b11 || w4_ph1 == 2'b11 || w4_ph2 == 2'b11)
                illegal_seen = 1'b1;
            if (mon_en && cur !== prev) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_wave: got 0x%0h with nothing expected (t=%0t)", cur, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("wave", {26'b0, cur}, {26'b0, e.wave});
                    check("wave_busy", {31'b0, busy}, {31'b0, e.busy});
                    check("wave_err", {31'b0, err}, {31'b0, e.err});
                    if (e.chk_idx) check("wave_phase_idx", {30'b0, phase_idx}, {30'b0, e.idx});
                end
            end
            prev = cur;
        end
    end

    task automatic check_idle_state(input string tag);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_err"}, {31'b0, err}, 32'd0);
        check({tag, "_phase_idx"}, {30'b0, phase_idx}, 32'd0);
        check({tag, "_queue_drained"}, exp_q.size(), 32'd0);
        check({tag, "_count"}, {16'b0, instr_count}, model_cnt & 32'hFFFF);
        check({tag, "_count_w4"}, {28'b0, w4_count}, model_cnt & 32'hF);
    endtask

    // Issue n instructions, drop run while the last PH1 data is up.
    task automatic run_episode(input int n, input bit held);
        int seen, cnt;
        logic prev1;
        if (held) begin
            mode = CORE_HOLD;
            repeat (5) @(negedge clk);
            run = 1'b1;
            for (int i = 0; i < n; i++) push_instr();
            repeat (10) @(negedge clk);
            check("held_ack_no_launch", {25'b0, PH0, PH1, PH2, busy}, 32'd0);
            #1 mode = CORE_AUTO;
            @(negedge clk);
            #1;
            check("held_ack_released", {31'b0, ack}, 32'd0);
            cnt = 0;
            while (PH0 !== 2'b10 && cnt < 20) begin
                @(posedge clk);
                #1;
                cnt++;
            end
            check("held_ack_latency", cnt, SYNC_STAGES + 1);
        end else begin
            run = 1'b1;
            for (int i = 0; i < n; i++) push_instr();
        end
        seen = 0;
        cnt = 0;
        prev1 = 1'b0;
        while (seen < n && cnt < 2000) begin
            @(negedge clk);
            cnt++;
            if (PH1 == 2'b10 && !prev1) seen++;
            prev1 = (PH1 == 2'b10);
        end
        check("ph1_reached", seen, n);
        run = 1'b0;
        cnt = 0;
        while (busy !== 1'b0 && cnt < 500) begin
            @(negedge clk);
            cnt++;
        end
        repeat (2) @(negedge clk);
        check_idle_state("episode_end");
        repeat ($urandom_range(1, 8)) @(negedge clk);
    endtask

    initial begin : stimulus
        int cnt;
        rst_n = 1'b0;
        run = 1'b0;
        mode = CORE_AUTO;
        mute_ph1 = 1'b0;
        mon_en = 1'b1;
        illegal_seen = 1'b0;
        model_cnt = 0;
        tests = 0;
        fails = 0;

        repeat (3) @(negedge clk);
        check("reset_wave", {26'b0, PH0, PH1, PH2}, 32'd0);
        check("reset_phase_idx", {30'b0, phase_idx}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_err", {31'b0, err}, 32'd0);
        check("reset_count", {16'b0, instr_count}, 32'd0);
        check("reset_count_w4", {28'b0, w4_count}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        run_episode(1, 1'b0);     // one instruction -> count 1
        run_episode(4, 1'b0);
        run_episode(5, 1'b0);     // ten total
        run_episode(2, 1'b1);     // launch held off by a stale ack
        run_episode(5, 1'b0);     // 17 total: 4-bit counter wraps to 1
        for (int i = 0; i < 3; i++) run_episode(int'($urandom_range(1, 3)), 1'b0);

        // Asynchronous reset while PH2 data is on the wires.
        run = 1'b1;
        push_instr();
        cnt = 0;
        while (PH2 !== 2'b10 && cnt < 500) begin
            @(negedge clk);
            cnt++;
        end
        check("ph2_reached", {31'b0, PH2 == 2'b10}, 32'd1);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_wave", {26'b0, PH0, PH1, PH2}, 32'd0);
        check("async_rst_phase_idx", {30'b0, phase_idx}, 32'd0);
        check("async_rst_count", {16'b0, instr_count}, 32'd0);
        check("async_rst_busy", {31'b0, busy}, 32'd0);
        run = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.delete();
        model_cnt = 0;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        mon_en = 1'b1;

        // Watchdog: the core never acknowledges PH1.
        mute_ph1 = 1'b1;
        run = 1'b1;
        exp_q.push_back(mk(ref_wave(0), 0, 1'b1, 1'b0, 1'b1));
        exp_q.push_back(mk(6'b0, 0, 1'b1, 1'b0, 1'b1));
        exp_q.push_back(mk(ref_wave(1), 1, 1'b1, 1'b0, 1'b1));
        exp_q.push_back(mk(6'b0, 0, 1'b0, 1'b1, 1'b0));
        cnt = 0;
        while (PH1 !== 2'b10 && cnt < 500) begin
            @(negedge clk);
            cnt++;
        end
        cnt = 0;
        while (err !== 1'b1 && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        check("timeout_cycles", cnt, TIMEOUT + 1);
        repeat (20) @(negedge clk);
        check("fault_err_sticky", {31'b0, err}, 32'd1);
        check("fault_busy", {31'b0, busy}, 32'd0);
        check("fault_wave", {26'b0, PH0, PH1, PH2}, 32'd0);
        check("fault_count_frozen", {16'b0, instr_count}, model_cnt & 32'hFFFF);
        check("fault_queue_drained", exp_q.size(), 32'd0);
        mute_ph1 = 1'b0;
        mon_en = 1'b0;
        run = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("fault_rst_err", {31'b0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_fault_err", {31'b0, err}, 32'd0);
        check("post_fault_busy", {31'b0, busy}, 32'd0);

        check("no_illegal_11", {31'b0, illegal_seen}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
